// File: rtl/tt_chan_pipe_param.sv
// Scan-chain user tile: CH registered channels with run-time selectable bypass, delay,
// edge-pulse or toggle behaviour, plus a primed flag and a wrapping channel-0 edge count.
module tt_chan_pipe_param #(
   parameter int CH    = 4,
   parameter int DEPTH = 8
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int CNTW = 3;
   localparam int FW   = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_DELAY  = 2'b01,
      MODE_EDGE   = 2'b10,
      MODE_TOGGLE = 2'b11
   } mode_e;

   logic          clk;
   logic          rst;
   logic [CH-1:0] d;
   mode_e         mode;

   assign clk  = io_in[0];
   assign rst  = io_in[1];
   assign d    = io_in[2+CH-1:2];
   assign mode = mode_e'(io_in[7:6]);

   logic [CH-1:0]   d_q, d_qq;
   logic [CH-1:0]   sr_q [DEPTH];
   logic [CH-1:0]   edge_q, edge_d;
   logic [CH-1:0]   tog_q, tog_d;
   logic [CH-1:0]   rise;
   mode_e           mode_q;
   logic [FW-1:0]   fill_q, fill_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CH-1:0]   ch_out;
   logic            primed;

   // d_qq clears on reset, so an input already high at release counts as a rise
   assign rise   = d_q & ~d_qq;
   assign edge_d = rise;
   assign tog_d  = tog_q ^ rise;
   assign cnt_d  = cnt_q + CNTW'(rise[0]);

   always_comb begin
      fill_d = fill_q;
      if (mode != mode_q) begin
         fill_d = '0;
      end else if (fill_q != FW'(DEPTH)) begin
         fill_d = fill_q + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q    <= '0;
         d_qq   <= '0;
         edge_q <= '0;
         tog_q  <= '0;
         mode_q <= MODE_BYPASS;
         fill_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         d_q    <= d;
         d_qq   <= d_q;
         edge_q <= edge_d;
         tog_q  <= tog_d;
         mode_q <= mode;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         sr_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   // selection follows the registered mode only, so a pin change never reaches the outputs directly
   always_comb begin
      ch_out = '0;
      case (mode_q)
         MODE_BYPASS: ch_out = d_q;
         MODE_DELAY:  ch_out = sr_q[DEPTH-1];
         MODE_EDGE:   ch_out = edge_q;
         MODE_TOGGLE: ch_out = tog_q;
         default:     ch_out = '0;
      endcase
   end

   assign primed = (fill_q == FW'(DEPTH));

   always_comb begin
      io_out         = '0;
      io_out[CH-1:0] = ch_out;
      io_out[4]      = primed;
      io_out[7:5]    = cnt_q;
   end

endmodule

// File: tb/tb_tt_chan_pipe_param.sv
// Bench for tt_chan_pipe_param: directed scenarios plus random traffic, all checked against
// a history-based reference model of the channel behaviour.
module tb_tt_chan_pipe_param;

   localparam int CH    = 4;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d   = 4'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int checks = 0;
   int errors = 0;

   // samples taken at each non-reset edge since the last reset edge
   logic [3:0] dh[$];
   logic [1:0] mh[$];

   assign io_in = {mode, d, rst, clk};

   tt_chan_pipe_param #(.CH(CH), .DEPTH(DEPTH)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      logic       r;
      logic [3:0] dd;
      logic [1:0] mm;
      r  = rst;
      dd = d;
      mm = mode;
      @(posedge clk);
      #1;
      if (r) begin
         dh.delete();
         mh.delete();
      end else begin
         dh.push_back(dd);
         mh.push_back(mm);
      end
   endtask

   function automatic logic [3:0] rise_at(int j);
      logic [3:0] prev;
      prev = (j > 0) ? dh[j-1] : 4'b0;
      return dh[j] & ~prev;
   endfunction

   function automatic logic [7:0] model_out();
      int         n, cnt, fill, c;
      logic [3:0] tog, chv, r;
      logic [1:0] prevm;
      n = dh.size() - 1;
      if (n < 0) return 8'h00;
      tog = '0;
      cnt = 0;
      for (int j = 0; j < n; j++) begin
         r   = rise_at(j);
         tog = tog ^ r;
         cnt = cnt + int'(r[0]);
      end
      c = -1;
      for (int j = 0; j <= n; j++) begin
         prevm = (j > 0) ? mh[j-1] : 2'b00;
         if (mh[j] != prevm) c = j;
      end
      fill = (c < 0) ? n + 1 : n - c;
      if (fill > DEPTH) fill = DEPTH;
      case (mh[n])
         2'b00:   chv = dh[n];
         2'b01:   chv = (n - DEPTH + 1 >= 0) ? dh[n-DEPTH+1] : 4'b0;
         2'b10:   chv = (n >= 1) ? rise_at(n-1) : 4'b0;
         default: chv = tog;
      endcase
      return {3'(cnt % 8), (fill == DEPTH), chv};
   endfunction

   task automatic test_reset();
      logic [7:0] exp;
      rst = 1'b1; d = 4'b1111; mode = 2'b11;
      step();
      step();
      exp = model_out();
      checks++;
      if (io_out !== exp || io_out !== 8'h00) begin
         errors++;
         $display("FAIL reset: io_out=%b expected %b", io_out, 8'h00);
      end
   endtask

   task automatic test_bypass();
      logic [7:0] exp;
      rst = 1'b1; d = 4'b0; mode = 2'b00;
      step();
      step();
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         d = (e == 5) ? 4'b1010 : 4'($urandom_range(0, 15));
         step();
         exp = model_out();
         checks++;
         if (io_out !== exp) begin
            errors++;
            $display("FAIL bypass_model edge %0d: io_out=%b expected %b", e, io_out, exp);
         end
         if (e == 5) begin
            checks++;
            if (io_out[3:0] !== 4'b1010) begin
               errors++;
               $display("FAIL bypass_edge5: out=%b expected 1010", io_out[3:0]);
            end
         end
         checks++;
         if (io_out[4] !== (e >= 8)) begin
            errors++;
            $display("FAIL bypass_primed edge %0d: primed=%b expected %b", e, io_out[4], (e >= 8));
         end
      end
   endtask

   task automatic test_delay();
      logic [7:0] exp;
      mode = 2'b01; d = 4'b0;
      for (int i = 0; i < 10; i++) step();
      d = 4'b0001;
      step();
      d = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         exp = model_out();
         checks++;
         if (io_out !== exp || io_out[0] !== (k == 7)) begin
            errors++;
            $display("FAIL delay t+%0d: io_out=%b expected %b out0=%b", k, io_out, exp, (k == 7));
         end
      end
   endtask

   task automatic test_edge();
      logic [7:0] exp, start;
      int hi, rises;
      logic prev;
      mode = 2'b10; d = 4'b0;
      for (int i = 0; i < 3; i++) step();
      start = model_out();
      hi = 0; rises = 0; prev = io_out[2];
      for (int c = 0; c < 14; c++) begin
         d = ((c < 5) || (c == 8)) ? 4'b0100 : 4'b0000;
         step();
         exp = model_out();
         checks++;
         if (io_out !== exp) begin
            errors++;
            $display("FAIL edge_model cycle %0d: io_out=%b expected %b", c, io_out, exp);
         end
         if (io_out[2]) hi++;
         if (io_out[2] && !prev) rises++;
         prev = io_out[2];
      end
      checks++;
      if (hi != 2 || rises != 2) begin
         errors++;
         $display("FAIL edge_pulses: high=%0d rises=%0d expected 2 and 2", hi, rises);
      end
      checks++;
      if (io_out[7:5] !== start[7:5]) begin
         errors++;
         $display("FAIL edge_count: cnt=%0d expected %0d", io_out[7:5], start[7:5]);
      end
   endtask

   task automatic test_toggle();
      logic [7:0] exp;
      logic want;
      rst = 1'b1; d = 4'b0; mode = 2'b11;
      step();
      rst = 1'b0;
      step();
      step();
      for (int p = 0; p < 3; p++) begin
         d = 4'b0010;
         step();
         d = 4'b0000;
         step();
         step();
         exp = model_out();
         want = (p != 1);
         checks++;
         if (io_out !== exp || io_out[1] !== want) begin
            errors++;
            $display("FAIL toggle pulse %0d: io_out=%b expected %b out1=%b", p, io_out, exp, want);
         end
      end
      mode = 2'b00;
      step();
      step();
      mode = 2'b11;
      step();
      step();
      exp = model_out();
      checks++;
      if (io_out !== exp || io_out[1] !== 1'b1) begin
         errors++;
         $display("FAIL toggle_keep: io_out=%b expected %b out1=1", io_out, exp);
      end
   endtask

   task automatic test_count_fill();
      logic [7:0] exp;
      rst = 1'b1; d = 4'b0; mode = 2'b01;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();
      for (int i = 0; i < 9; i++) begin
         d = 4'b0001;
         if (i == 2) mode = 2'b10;
         step();
         if (i == 2) begin
            checks++;
            if (io_out[4] !== 1'b0) begin
               errors++;
               $display("FAIL fill_drop: primed=%b expected 0", io_out[4]);
            end
         end
         exp = model_out();
         checks++;
         if (io_out !== exp) begin
            errors++;
            $display("FAIL count_model rise %0d: io_out=%b expected %b", i, io_out, exp);
         end
         d = 4'b0000;
         step();
         exp = model_out();
         checks++;
         if (io_out !== exp) begin
            errors++;
            $display("FAIL count_model low %0d: io_out=%b expected %b", i, io_out, exp);
         end
      end
      step();
      step();
      checks++;
      if (io_out[7:5] !== 3'd1 || io_out[4] !== 1'b1) begin
         errors++;
         $display("FAIL count_wrap: cnt=%0d primed=%b expected 1 and 1", io_out[7:5], io_out[4]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      mode = 2'b01; d = 4'b1111;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (io_out[3:0] !== 4'b1111) begin
         errors++;
         $display("FAIL rstmid_full: out=%b expected 1111", io_out[3:0]);
      end
      rst = 1'b1;
      step();
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_clear: io_out=%b expected 00000000", io_out);
      end
      rst = 1'b0; d = 4'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         exp = model_out();
         checks++;
         if (io_out !== exp || io_out[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_release %0d: io_out=%b expected %b", i, io_out, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         d   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         step();
         exp = model_out();
         checks++;
         if (io_out !== exp) begin
            errors++;
            $display("FAIL random step %0d: io_out=%b expected %b", i, io_out, exp);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_delay();
      test_edge();
      test_toggle();
      test_count_fill();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
